// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    Rel,
    DbPress,
    Pressed,
    DbRel
  } btn_state_e;

  localparam int unsigned DefaultNBtn           = 4;
  localparam int unsigned DefaultDebounceCycles = 1000000;
  localparam int unsigned DefaultLongCycles     = 50000000;

  // Both counters share one width, wide enough to hold the long-press limit itself.
  function automatic int unsigned cnt_width(int unsigned long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Board-key inputs and debounced outputs of the button debouncer, one bit per channel.
interface button_debounce_if #(
  parameter int unsigned N_BTN = 4
);

  logic [N_BTN-1:0] key_n;
  logic [N_BTN-1:0] btn_db_n;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;

  modport master (
    output key_n,
    input  btn_db_n,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  key_n,
    output btn_db_n,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );

endinterface

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, debounce and hold counters.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned LONG_CYCLES     = DefaultLongCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic btn_db_n_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o
);

  localparam int unsigned CntW = cnt_width(LONG_CYCLES);

  localparam logic [CntW-1:0] DbLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] LongMax = CntW'(LONG_CYCLES);
  localparam logic [CntW-1:0] LongPre = CntW'(LONG_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            sync_n;
  btn_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] hold_q;
  logic            btn_q;
  logic            press_q;
  logic            release_q;
  logic            long_q;

  assign sync_n = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      state_q   <= Rel;
      cnt_q     <= '0;
      hold_q    <= '0;
      btn_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      unique case (state_q)
        Rel: begin
          if (!sync_n) begin
            state_q <= DbPress;
            cnt_q   <= '0;
          end
        end
        DbPress: begin
          if (sync_n) begin
            state_q <= Rel;
          end else if (cnt_q == DbLast) begin
            state_q <= Pressed;
            btn_q   <= 1'b0;
            press_q <= 1'b1;
            hold_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        Pressed: begin
          if (sync_n) begin
            state_q <= DbRel;
            cnt_q   <= '0;
          end else if (hold_q != LongMax) begin
            // Saturation at LongMax is what makes the long pulse fire only once per press.
            hold_q <= hold_q + 1'b1;
            long_q <= (hold_q == LongPre);
          end
        end
        DbRel: begin
          // hold_q is deliberately left alone so a release glitch cannot re-arm the long press.
          if (!sync_n) begin
            state_q <= Pressed;
          end else if (cnt_q == DbLast) begin
            state_q   <= Rel;
            btn_q     <= 1'b1;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= Rel;
      endcase
    end
  end

  assign btn_db_n_o      = btn_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign long_pulse_o    = long_q;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer with press, release and long-press strobes.
module button_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = DefaultNBtn,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned LONG_CYCLES     = DefaultLongCycles
) (
  input logic             clk_clk,
  input logic             reset_reset,
  button_debounce_if.slave bus
);

  logic [N_BTN-1:0] btn_db_n;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk_i          (clk_clk),
      .rst_i          (reset_reset),
      .key_n_i        (bus.key_n[i]),
      .btn_db_n_o     (btn_db_n[i]),
      .press_pulse_o  (press_pulse[i]),
      .release_pulse_o(release_pulse[i]),
      .long_pulse_o   (long_pulse[i])
    );
  end

  assign bus.btn_db_n      = btn_db_n;
  assign bus.press_pulse   = press_pulse;
  assign bus.release_pulse = release_pulse;
  assign bus.long_pulse    = long_pulse;

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter: N_BTN, 4, number of independent push-button channels.
REQ-002 Parameter: DEBOUNCE_CYCLES, 1000000, cycles of stable input required to accept a change (20 ms at 50 MHz); legal range 2 to 2^24.
REQ-003 Parameter: LONG_CYCLES, 50000000, cycles in the pressed state before a long-press pulse fires (1 s at 50 MHz); SHALL be greater than DEBOUNCE_CYCLES.
REQ-004 Port: clk_clk  input  1  system clock; the block is in a single clock domain.
REQ-005 Port: reset_reset  input  1  reset, synchronous, active-high.
REQ-006 Port: key_n  input  N_BTN  raw board KEY pins, active-low, asynchronous to clk_clk.
REQ-007 Port: btn_db_n  output  N_BTN  debounced level, active-low; drives button_pio_external_connection_export.
REQ-008 Port: press_pulse  output  N_BTN  one-cycle strobe on an accepted press.
REQ-009 Port: release_pulse  output  N_BTN  one-cycle strobe on an accepted release.
REQ-010 Port: long_pulse  output  N_BTN  one-cycle strobe when a press has been held for LONG_CYCLES.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchronizer; all later logic SHALL use only the synchronized bit (sync_n).
REQ-012 Each channel SHALL run an independent FSM with states REL (released), DB_PRESS, PRESSED and DB_REL.
REQ-013 REL: if sync_n=0, go to DB_PRESS and clear the counter; otherwise stay.
REQ-014 DB_PRESS: if sync_n=1, return to REL with no output change; otherwise increment the counter; when the counter reaches DEBOUNCE_CYCLES-1, go to PRESSED.
REQ-015 PRESSED: if sync_n=1, go to DB_REL and clear the counter; otherwise increment the hold counter, saturating at LONG_CYCLES.
REQ-016 DB_REL: if sync_n=0, return to PRESSED; the hold counter SHALL keep its value, so a glitch does not re-arm the long press. Otherwise increment the counter; when it reaches DEBOUNCE_CYCLES-1, go to REL.
REQ-017 btn_db_n[i] SHALL be 0 exactly in PRESSED and DB_REL, and SHALL be registered.
REQ-018 Latency: a clean edge on key_n SHALL change btn_db_n DEBOUNCE_CYCLES+2 cycles after the first rising clk_clk edge that samples the new value.
REQ-019 press_pulse[i] SHALL be high for exactly the one cycle in which btn_db_n[i] first reads 0; release_pulse[i] SHALL behave likewise for the first cycle at 1.
REQ-020 long_pulse[i] SHALL fire exactly once per accepted press, in the cycle in which the hold counter reaches LONG_CYCLES; a release before that point SHALL produce no long_pulse.
REQ-021 Counters SHALL be $clog2(LONG_CYCLES+1) bits wide and unsigned, with no wrap-around; the hold counter SHALL saturate.
REQ-022 Simultaneous activity on several channels SHALL be handled independently; any pulses may coincide in the same cycle.
REQ-023 Each bounce period shorter than DEBOUNCE_CYCLES SHALL restart debouncing and SHALL produce no pulse.

Reset
REQ-024 While reset_reset=1, all FSMs SHALL be in REL, counters at 0, synchronizer flops at 1, btn_db_n all 1, and all pulse outputs 0.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse emitted; after release, a held key SHALL be re-debounced from REL.

Structure
REQ-026 Package btn_pkg SHALL hold the state enum (REL, DB_PRESS, PRESSED, DB_REL) and the default cycle constants.
REQ-027 One sub-module, btn_channel (synchronizer, FSM and counters for one bit), SHALL be instantiated N_BTN times by a generate loop.

Verification (DEBOUNCE_CYCLES=8, LONG_CYCLES=32)
REQ-028 key_n[0] 1->0 held for 40 cycles -> btn_db_n[0]=0 at cycle 10, press_pulse[0] high in cycle 10 only, long_pulse[0] one cycle at cycle 42.
REQ-029 key_n[1] toggling every 3 cycles for 30 cycles, then held at 1 -> btn_db_n[1] stays 1 and no pulses on any output.
REQ-030 Accepted press, then key_n 0->1 for 5 cycles and back to 0 -> no release_pulse, btn_db_n stays 0, no second long_pulse.
REQ-031 All four keys pressed in the same cycle -> all four press_pulse bits high in the same cycle; released 20 cycles later -> four release_pulse bits coincide.
REQ-032 reset_reset pulsed in DB_PRESS (counter=5) -> outputs at reset values, no pulses; key still low -> press accepted 10 cycles after reset deasserts.
